// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: types shared by the IFU/LSU memory-port arbiter and its grant selector.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_WAIT_IF = 2'd1,
    ARB_WAIT_LS = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } arb_gnt_t;

  // Bit positions inside the 2-bit request vector handed to arb_pick
  localparam int unsigned REQ_IF = 0;
  localparam int unsigned REQ_LS = 1;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: 2-way combinational grant selector; fixed LSU > IFU by default,
// round-robin on contention when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_gnt_t   last_grant,
  output arb_gnt_t   grant
);

`ifdef MEM_ARB_RR_EN
  // On contention hand the port to the master that did not win last time
  always_comb begin
    grant = GNT_IF;
    if (req[REQ_IF] && req[REQ_LS]) begin
      grant = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
    end else if (req[REQ_LS]) begin
      grant = GNT_LS;
    end else begin
      grant = GNT_IF;
    end
  end
`else
  // Fixed priority needs neither the IFU request bit nor the grant history
  logic unused_pick_s;
  assign unused_pick_s = ^{req[REQ_IF], last_grant};

  // Fixed priority: the LSU always wins
  always_comb begin
    grant = GNT_IF;
    if (req[REQ_LS]) begin
      grant = GNT_LS;
    end else begin
      grant = GNT_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed LSU priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_kill,
  output logic                  if_rsp_valid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req_valid,
  output logic                  ls_req_ready,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic                  ls_wen,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_rsp_valid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  arb_err
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_t state_r;
  arb_state_t state_nxt_s;
  logic       kill_pending_r;
  logic       kill_pending_nxt_s;
  logic       arb_err_r;
  logic       accept_s;
  arb_gnt_t   grant_s;
  arb_gnt_t   last_grant_s;

`ifdef MEM_ARB_RR_EN
  arb_gnt_t last_grant_r;

  // Most recent winner, feeding the round-robin tie-break
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GNT_IF;
    end else if (accept_s) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign last_grant_s = last_grant_r;
`else
  assign last_grant_s = GNT_IF;
`endif

  arb_pick u_pick (
    .req        ({ls_req_valid, if_req_valid}),
    .last_grant (last_grant_s),
    .grant      (grant_s)
  );

  // Request routing, handshakes, response steering and next-state logic
  always_comb begin
    state_nxt_s        = state_r;
    kill_pending_nxt_s = kill_pending_r;
    accept_s           = 1'b0;
    mem_req_valid      = 1'b0;
    if_req_ready       = 1'b0;
    ls_req_ready       = 1'b0;
    if_rsp_valid       = 1'b0;
    ls_rsp_valid       = 1'b0;
    if_rdata           = mem_rdata;
    ls_rdata           = mem_rdata;
    if (grant_s == GNT_LS) begin
      mem_addr  = ls_addr;
      mem_wen   = ls_wen;
      mem_wdata = ls_wdata;
      mem_wmask = ls_wmask;
    end else begin
      mem_addr  = if_addr;
      mem_wen   = 1'b0;
      mem_wdata = {DATA_W{1'b0}};
      mem_wmask = {MASK_W{1'b0}};
    end

    if (rst) begin
      state_nxt_s        = ARB_IDLE;
      kill_pending_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          mem_req_valid = if_req_valid | ls_req_valid;
          accept_s      = mem_req_valid & mem_req_ready;
          if (grant_s == GNT_LS) begin
            ls_req_ready = accept_s;
            state_nxt_s  = accept_s ? ARB_WAIT_LS : ARB_IDLE;
          end else begin
            if_req_ready = accept_s;
            state_nxt_s  = accept_s ? ARB_WAIT_IF : ARB_IDLE;
          end
          // A kill in the very cycle the fetch is accepted already condemns it
          if (accept_s) begin
            kill_pending_nxt_s = (grant_s == GNT_IF) & if_kill;
          end else begin
            kill_pending_nxt_s = kill_pending_r;
          end
        end
        ARB_WAIT_IF: begin
          if_rsp_valid       = mem_rsp_valid & ~kill_pending_r & ~if_kill;
          kill_pending_nxt_s = kill_pending_r | if_kill;
          state_nxt_s        = mem_rsp_valid ? ARB_IDLE : ARB_WAIT_IF;
        end
        ARB_WAIT_LS: begin
          ls_rsp_valid = mem_rsp_valid;
          state_nxt_s  = mem_rsp_valid ? ARB_IDLE : ARB_WAIT_LS;
        end
        default: begin
          state_nxt_s        = ARB_IDLE;
          kill_pending_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // FSM state, kill tracking and the sticky stray-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ARB_IDLE;
      kill_pending_r <= 1'b0;
      arb_err_r      <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      kill_pending_r <= kill_pending_nxt_s;
      if ((state_r == ARB_IDLE) && mem_rsp_valid) begin
        arb_err_r <= 1'b1;
      end else begin
        arb_err_r <= arb_err_r;
      end
    end
  end

  assign arb_err = arb_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random IFU/LSU traffic against a reference memory and
// transaction model; a negedge monitor scores every handshake and response.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              if_req_valid, if_req_ready, if_kill, if_rsp_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req_valid, ls_req_ready, ls_wen, ls_rsp_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata, ls_rdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              arb_err;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_kill(if_kill), .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              killed;
    logic              chk;
  } exp_t;

  exp_t              if_q[$];
  exp_t              ls_q[$];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] slv_mem [logic [ADDR_W-1:0]];

  int          n_chk = 0, n_fail = 0;
  int          n_if_rsp = 0, n_ls_rsp = 0, n_kill_drop = 0;
  bit          mem_busy = 1'b0, exp_err = 1'b0;
  arb_gnt_t    owner = GNT_IF, last_win = GNT_IF;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'd0;
  bit          if_acc = 1'b0, ls_acc = 1'b0;
  bit          en_if = 1'b0, en_ls = 1'b0, en_rsp = 1'b1, en_rdy = 1'b0;

  function automatic logic [DATA_W-1:0] seed(input logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed(a);
  endfunction

  function automatic logic [DATA_W-1:0] slv_rd(input logic [ADDR_W-1:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : seed(a);
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [MASK_W-1:0] wm);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < MASK_W; b++) if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 32'h8000_0000 + {26'd0, 3'($urandom_range(0, 7)), 3'b000};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: predicts handshakes/responses from the transaction model
  always @(negedge clk) begin : mon
    logic     exp_v, exp_ifr, exp_lsr, exp_ifv, exp_lsv;
    arb_gnt_t win;
    exp_t     e;
    check1("arb_err", arb_err, exp_err);

    exp_v = !rst && !mem_busy && (if_req_valid || ls_req_valid);
`ifdef MEM_ARB_RR_EN
    if (if_req_valid && ls_req_valid) win = (last_win == GNT_LS) ? GNT_IF : GNT_LS;
    else win = ls_req_valid ? GNT_LS : GNT_IF;
`else
    win = ls_req_valid ? GNT_LS : GNT_IF;
`endif
    exp_ifr = exp_v && (win == GNT_IF) && mem_req_ready;
    exp_lsr = exp_v && (win == GNT_LS) && mem_req_ready;
    if (exp_v || mem_req_valid) check1("mem_req_valid", mem_req_valid, exp_v);
    if (exp_ifr || if_req_ready) check1("if_req_ready", if_req_ready, exp_ifr);
    if (exp_lsr || ls_req_ready) check1("ls_req_ready", ls_req_ready, exp_lsr);
    if (exp_v) begin
      if (win == GNT_LS) begin
        checkw("mem_addr_ls", 64'(mem_addr), 64'(ls_addr));
        check1("mem_wen_ls", mem_wen, ls_wen);
        checkw("mem_wdata_ls", mem_wdata, ls_wdata);
        checkw("mem_wmask_ls", 64'(mem_wmask), 64'(ls_wmask));
      end else begin
        checkw("mem_addr_if", 64'(mem_addr), 64'(if_addr));
        check1("mem_wen_if", mem_wen, 1'b0);
        checkw("mem_wmask_if", 64'(mem_wmask), 64'd0);
      end
    end

    exp_ifv = 1'b0;
    exp_lsv = 1'b0;
    e.data = 64'd0; e.killed = 1'b0; e.chk = 1'b0;
    if (!rst && mem_rsp_valid && mem_busy) begin
      if (owner == GNT_IF && if_q.size() > 0) begin
        e = if_q.pop_front();
        exp_ifv = !e.killed && !if_kill;
        if (!exp_ifv) n_kill_drop++;
      end else if (owner == GNT_LS && ls_q.size() > 0) begin
        e = ls_q.pop_front();
        exp_lsv = 1'b1;
      end
    end
    if (exp_ifv || if_rsp_valid) check1("if_rsp_valid", if_rsp_valid, exp_ifv);
    if (exp_ifv && if_rsp_valid) begin
      checkw("if_rdata", if_rdata, e.data);
      n_if_rsp++;
    end
    if (exp_lsv || ls_rsp_valid) check1("ls_rsp_valid", ls_rsp_valid, exp_lsv);
    if (exp_lsv && ls_rsp_valid) begin
      if (e.chk) checkw("ls_rdata", ls_rdata, e.data);
      n_ls_rsp++;
    end

    if (rst) begin
      mem_busy = 1'b0;
      exp_err  = 1'b0;
      last_win = GNT_IF;
      if_q.delete();
      ls_q.delete();
    end else begin
      if (mem_busy && owner == GNT_IF && if_kill && if_q.size() > 0) if_q[0].killed = 1'b1;
      if (mem_rsp_valid) begin
        if (mem_busy) mem_busy = 1'b0;
        else exp_err = 1'b1;
      end
      if (exp_v && mem_req_ready) begin
        last_win = win;
        owner    = win;
        mem_busy = 1'b1;
        rsp_cnt  = int'($urandom_range(1, 4));
        rsp_addr = mem_addr;
        if (mem_wen) slv_mem[mem_addr] = merge(slv_rd(mem_addr), mem_wdata, mem_wmask);
        if (win == GNT_IF) begin
          e.data = ref_rd(if_addr); e.killed = if_kill; e.chk = 1'b1;
          if_q.push_back(e);
          if_acc = 1'b1;
        end else begin
          e.data = ref_rd(ls_addr); e.killed = 1'b0; e.chk = !ls_wen;
          if (ls_wen) ref_mem[ls_addr] = merge(ref_rd(ls_addr), ls_wdata, ls_wmask);
          ls_q.push_back(e);
          ls_acc = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (if_acc) begin if_req_valid = 1'b0; if_acc = 1'b0; end
    if (ls_acc) begin ls_req_valid = 1'b0; ls_acc = 1'b0; end
    if (en_if && !if_req_valid && $urandom_range(0, 2) == 0) begin
      if_req_valid = 1'b1;
      if_addr      = rand_addr();
    end
    if (en_ls && !ls_req_valid && $urandom_range(0, 2) == 0) begin
      ls_req_valid = 1'b1;
      ls_addr      = rand_addr();
      ls_wen       = 1'($urandom_range(0, 1));
      ls_wdata     = {$urandom, $urandom};
      ls_wmask     = 8'($urandom_range(0, 255));
    end
    if_kill = en_if && ($urandom_range(0, 5) == 0);
    if (en_rdy) mem_req_ready = ($urandom_range(0, 3) != 0);
    if (en_rsp) begin
      mem_rsp_valid = 1'b0;
      mem_rdata     = {$urandom, $urandom};
      if (mem_busy) begin
        if (rsp_cnt <= 1) begin
          mem_rsp_valid = 1'b1;
          mem_rdata     = slv_rd(rsp_addr);
        end else begin
          rsp_cnt--;
        end
      end
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = 32'd0; if_kill = 1'b0;
    ls_req_valid = 1'b0; ls_addr = 32'd0; ls_wen = 1'b0; ls_wdata = 64'd0; ls_wmask = 8'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 64'd0;
    repeat (3) step();
    rst = 1'b0;
    en_if = 1'b1; en_ls = 1'b1; en_rdy = 1'b1;
    repeat (3000) step();

    // Quiesce, then reset in the middle of a load and send its late response
    en_if = 1'b0; en_ls = 1'b0;
    step();
    if_req_valid = 1'b0; ls_req_valid = 1'b0; if_kill = 1'b0;
    guard = 0;
    while (mem_busy && guard < 20) begin step(); guard++; end
    check1("drain_timeout", mem_busy, 1'b0);
    en_rsp = 1'b0; en_rdy = 1'b0;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    ls_req_valid = 1'b1; ls_addr = 32'h8000_1000; ls_wen = 1'b0;
    step();
    check1("ls_accept_directed", ls_req_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 64'h13;
    step();
    mem_rsp_valid = 1'b0;
    repeat (3) step();
    check1("arb_err_sticky", arb_err, 1'b1);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    check1("arb_err_cleared", arb_err, 1'b0);

    check1("if_rsp_seen", n_if_rsp > 0, 1'b1);
    check1("ls_rsp_seen", n_ls_rsp > 0, 1'b1);
    check1("kill_drop_seen", n_kill_drop > 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-master, one-slave arbiter that shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Sits between the pipeline front end / execute stage and `memory`.
- Allows at most one outstanding transaction and locks the grant from request acceptance until response.
- Supports discarding an in-flight fetch on pipeline flush.

## Interface
Parameters:
- ADDR_W, 32, address width (matches `AddrWidth`)
- DATA_W, 64, data width (matches `RegWidth`); mask width is DATA_W/8

Ports (name direction width meaning):
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- if_req_valid  in  1  IFU read request
- if_req_ready  out  1  IFU request accepted this cycle
- if_addr  in  ADDR_W  IFU address
- if_kill  in  1  flush: discard pending IFU response
- if_rsp_valid  out  1  IFU response valid, 1-cycle pulse
- if_rdata  out  DATA_W  IFU read data
- ls_req_valid  in  1  LSU request
- ls_req_ready  out  1  LSU request accepted this cycle
- ls_addr  in  ADDR_W  LSU address
- ls_wen  in  1  1 = store, 0 = load
- ls_wdata  in  DATA_W  store data
- ls_wmask  in  DATA_W/8  byte enables
- ls_rsp_valid  out  1  LSU response/ack, 1-cycle pulse
- ls_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  forwarded request fields; IFU drives wen=0, mask=0
- mem_rsp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- arb_err  out  1  sticky: response received with no transaction outstanding

## Operation
States:
- IDLE
- WAIT_IF
- WAIT_LS

IDLE:
- Select a winner among the valid requesters; fixed priority LSU > IFU unless round-robin is compiled in (see Configuration).
- Drive `mem_req_*` combinationally from the winner's fields.
- Winner's `*_req_ready` = `mem_req_ready`; loser's ready = 0.
- On `mem_req_valid && mem_req_ready`: go to WAIT_IF or WAIT_LS; clear `kill_pending`.

WAIT_x:
- `mem_req_valid` = 0; both readies = 0.
- On `mem_rsp_valid`: drive the owner's `*_rsp_valid` = 1 and `*_rdata` = `mem_rdata` combinationally, same cycle; return to IDLE.

Kill:
- `if_kill` in WAIT_IF, or in the IDLE cycle the IFU is accepted, sets `kill_pending`.
- The matching response is consumed: `if_rsp_valid` stays 0, and the state still returns to IDLE.
- `if_kill` in any other state or situation has no effect.

Errors:
- `mem_rsp_valid` in IDLE: response dropped, `arb_err` set.
- `arb_err` is cleared only by rst.

Other rules:
- Non-owner `*_rsp_valid` is always 0.
- `*_rdata` may carry `mem_rdata` unconditionally; consumers qualify it with `*_rsp_valid`.

## Timing
- Reset (rst high at posedge): state=IDLE, kill_pending=0, last_grant=IFU, arb_err=0.
- While rst is high, all valid/ready outputs are forced to 0.
- Reset mid-transaction abandons the transaction; a late response then sets arb_err.
- Request acceptance: same cycle as `mem_req_ready`, zero added latency.
- Response: passes through with zero cycles latency.
- Minimum gap: one bubble cycle between a response and the next acceptance, because the arbiter must be in IDLE to grant.
- Back-to-back throughput: one transaction per (memory latency + 1) cycles.
- Simultaneous requests in IDLE: exactly one granted; the loser holds valid and is served on the next IDLE.
- Requester contract: `*_req_valid` and its fields stay stable until ready; a dropped valid before ready is permitted (no transaction).
- `if_kill` and `mem_rsp_valid` in the same WAIT_IF cycle: response suppressed.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests, grant the master not equal to `last_grant`.
  - `last_grant` updates on every acceptance.
  - This guarantees neither master waits more than one foreign transaction.
- Undefined: fixed priority LSU > IFU.
  - The `last_grant` register is not instantiated.
  - IFU can starve under continuous LSU traffic (acceptable: the LSU stalls the pipeline).

## Structure
- Shared package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT_IF, ARB_WAIT_LS} arb_state_t`
  - `typedef enum logic {GNT_IF, GNT_LS} arb_gnt_t`
- Sub-module `arb_pick`: a 2-way combinational grant selector with inputs req[1:0] and last_grant, and a grant output. The RR/fixed selection is isolated here under the macro.
- The FSM, kill tracking, error flag and routing muxes live in `mem_arbiter`.

## Test plan
- IFU only, addr 0x80000000, memory ready immediately, response 3 cycles later with rdata 0x13 -> if_rsp_valid pulses 1 cycle with 0x13; next acceptance no earlier than 1 cycle later.
- Both request in the same IDLE cycle -> LSU granted. With `MEM_ARB_RR_EN`, a second simultaneous request -> IFU granted; without it -> LSU again.
- LSU store, addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F -> mem fields match exactly; ls_rsp_valid pulses on the ack; if_rsp_valid stays 0.
- IFU accepted, if_kill asserted 1 cycle later, response arrives -> if_rsp_valid stays 0, state IDLE, a pending LSU request is granted the next cycle.
- mem_req_ready held 0 for 4 cycles -> ls_req_ready stays 0, request fields stable, no state change; accepted on cycle 5.
- rst asserted in WAIT_LS, then mem_rsp_valid -> ls_rsp_valid stays 0, arb_err=1 and holds until the next rst.
